// File: rtl/data_sram_resp.sv
// Data SRAM with a one-entry coalescing write buffer; reads forward buffered bytes.
// Read data registered with 1-cycle latency; no backpressure, a request is accepted every cycle.
module data_sram_resp #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        addr_err,
  output logic        wbuf_pending
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem [DEPTH];
  logic                 wb_vld;
  logic [ADDR_BITS-1:0] wb_idx;
  logic [31:0]          wb_dat;
  logic [3:0]           wb_msk;

  logic [ADDR_BITS-1:0] idx;
  logic                 oor, is_wr, is_rd, hit;
  logic                 drain, capture, merge;
  logic [31:0]          merged_dat, fwd_dat;
  logic                 unused_addr_lsbs;

  assign idx              = data_sram_addr[ADDR_BITS+1:2];
  assign unused_addr_lsbs = ^data_sram_addr[1:0];
  assign oor   = data_sram_en && (data_sram_addr[31:ADDR_BITS+2] != '0);
  assign is_wr = data_sram_en && (data_sram_wen != 4'b0000) && !oor;
  assign is_rd = data_sram_en && (data_sram_wen == 4'b0000);
  assign hit   = wb_vld && (wb_idx == idx);

  // Any cycle that is not a same-word write retires the buffered entry.
  assign drain   = wb_vld && !(is_wr && hit);
  assign capture = is_wr && !hit;
  assign merge   = is_wr && hit;

  always_comb begin
    merged_dat = wb_dat;
    fwd_dat    = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (data_sram_wen[b]) merged_dat[8*b +: 8] = data_sram_wdata[8*b +: 8];
      if (hit && wb_msk[b]) fwd_dat[8*b +: 8] = wb_dat[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_vld          <= 1'b0;
      data_sram_rdata <= 32'h0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= oor;
      if (is_rd) data_sram_rdata <= oor ? 32'h0 : fwd_dat;
      if (capture) begin
        wb_vld <= 1'b1;
        wb_idx <= idx;
        wb_dat <= data_sram_wdata;
        wb_msk <= data_sram_wen;
      end else if (merge) begin
        wb_dat <= merged_dat;
        wb_msk <= wb_msk | data_sram_wen;
      end else if (drain) begin
        wb_vld <= 1'b0;
      end
    end
  end

  // Array is never reset; a drain coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_msk[b]) mem[wb_idx][8*b +: 8] <= wb_dat[8*b +: 8];
      end
    end
  end

  assign wbuf_pending = wb_vld;
endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: stimulus pushes expected per-cycle outputs, monitor pops and compares.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        addr_err;
  logic        wbuf_pending;

  data_sram_resp #(.ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .addr_err(addr_err), .wbuf_pending(wbuf_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        aerr;
    logic        chk_pend;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  bit   [31:0] refm [1024];
  logic [31:0] last_rd = 32'h0;
  int          checks = 0;
  int          errors = 0;
  bit          stim_done = 1'b0;

  // Monitor: each sampled edge pops the expectation pushed for the request seen at that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.rd) begin
          errors++;
          $display("FAIL rdata: got %h want %h at %0t", rdata, e.rd, $time);
        end
        checks++;
        if (addr_err !== e.aerr) begin
          errors++;
          $display("FAIL addr_err: got %b want %b at %0t", addr_err, e.aerr, $time);
        end
        if (e.chk_pend) begin
          checks++;
          if (wbuf_pending !== e.pend) begin
            errors++;
            $display("FAIL wbuf_pending: got %b want %b at %0t", wbuf_pending, e.pend, $time);
          end
        end
      end
    end
  end

  function automatic bit in_range(input logic [31:0] a);
    return a[31:12] == 20'h0;
  endfunction

  task automatic push(input logic aerr, input logic chk_pend, input logic pend);
    exp_t e;
    e.rd = last_rd; e.aerr = aerr; e.chk_pend = chk_pend; e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; en = 1'b0; wen = 4'b0;
      last_rd = 32'h0;
      push(1'b0, 1'b1, 1'b0);
    end
  endtask

  // Write: updates reference memory byte-wise when in range.
  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                    input logic chk_pend, input logic pend);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; wen = m; addr = a; wdata = d;
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (m[b]) refm[a[11:2]][8*b +: 8] = d[8*b +: 8];
    push(!in_range(a), chk_pend, pend);
  endtask

  // Directed read with a hand-computed expected value.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp_v,
                    input logic chk_pend, input logic pend);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; wen = 4'b0; addr = a; wdata = 32'h0;
    last_rd = exp_v;
    push(!in_range(a), chk_pend, pend);
  endtask

  task automatic idle(input logic chk_pend, input logic pend);
    @(negedge clk);
    reset = 1'b0; en = 1'b0; wen = 4'b0;
    addr = $urandom; wdata = $urandom;
    push(1'b0, chk_pend, pend);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  m;
    int          wait_cyc;

    do_reset(2);

    // Known contents: word i = {i, ~i}.
    for (int i = 0; i < 1024; i++) begin
      d = {i[15:0], ~i[15:0]};
      wr(i * 4, 4'hF, d, 1'b0, 1'b0);
    end
    idle(1'b1, 1'b0);

    // Write then read forwarded from the buffer; read edge drains it.
    wr(32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
    rd(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    rd(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);

    // Byte merge into the same buffered word.
    wr(32'h20, 4'hF, 32'h11223344, 1'b1, 1'b1);
    idle(1'b1, 1'b0);
    wr(32'h20, 4'b0001, 32'h000000AA, 1'b1, 1'b1);
    wr(32'h20, 4'b0100, 32'h00BB0000, 1'b1, 1'b1);
    rd(32'h20, 32'h11BB33AA, 1'b1, 1'b0);
    rd(32'h20, 32'h11BB33AA, 1'b1, 1'b0);

    // Back-to-back different words: pending for exactly two cycles.
    wr(32'h40, 4'hF, 32'h1, 1'b1, 1'b1);
    wr(32'h44, 4'hF, 32'h2, 1'b1, 1'b1);
    idle(1'b1, 1'b0);
    rd(32'h40, 32'h1, 1'b1, 1'b0);
    rd(32'h44, 32'h2, 1'b1, 1'b0);

    // Out-of-range read and out-of-range write draining the buffer.
    rd(32'h0001_0000, 32'h0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    wr(32'h60, 4'hF, 32'h77, 1'b1, 1'b1);
    wr(32'h0001_0060, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(32'h60, 32'h77, 1'b1, 1'b0);
    rd(32'h64, 32'h0019_FFE6, 1'b1, 1'b0);
    rd(32'h0, 32'h0000_FFFF, 1'b1, 1'b0);

    // Drain and a read of another word in the same cycle.
    wr(32'h100, 4'b0011, 32'h0000_CAFE, 1'b1, 1'b1);
    rd(32'h104, 32'h0041_FFBE, 1'b1, 1'b0);
    rd(32'h100, 32'h0040_CAFE, 1'b1, 1'b0);

    // Buffered write lost at reset.
    wr(32'h80, 4'hF, 32'h55, 1'b1, 1'b1);
    refm[32] = 32'h0020_FFDF;
    do_reset(1);
    rd(32'h80, 32'h0020_FFDF, 1'b1, 1'b0);

    // Random mix against the reference memory.
    for (int i = 0; i < 10000; i++) begin
      a = {$urandom_range(0, 15), 2'(i)};
      if ($urandom_range(0, 15) == 0) a[20] = 1'b1;
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) m = 4'b0;
      if ($urandom_range(0, 3) == 0) idle(1'b0, 1'b0);
      else if (m == 4'b0) rd(a, in_range(a) ? refm[a[11:2]] : 32'h0, 1'b0, 1'b0);
      else wr(a, m, $urandom, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
